// File: rtl/wb_burst_master.sv
// wb_burst_master: command stream to Wishbone B3 single/incrementing-burst master.
// Latency: WB cycle starts one clock after command handshake; read data one clock after ACK.
// Backpressure: cmd_ready only in IDLE, wr_ready only in WLOAD; rd stream has none.
module wb_burst_master #(
  parameter int AW      = 26,
  parameter int DW      = 32,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 256
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  // command stream
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  // write beat stream
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [DW-1:0]    wr_data,
  // read beat stream
  output logic             rd_valid,
  output logic [DW-1:0]    rd_data,
  // status
  output logic             busy,
  output logic             err_timeout,
  // Wishbone master side
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic             wb_we_o,
  output logic [AW-1:0]    wb_addr_o,
  output logic [DW-1:0]    wb_dat_o,
  output logic [DW/8-1:0]  wb_sel_o,
  output logic [2:0]       wb_cti_o,
  input  logic             wb_ack_i,
  input  logic [DW-1:0]    wb_dat_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WLOAD,
    S_STB,
    S_GAP
  } state_t;

  localparam logic [2:0]    CTI_CLASSIC = 3'b000;
  localparam logic [2:0]    CTI_INCR    = 3'b010;
  localparam logic [2:0]    CTI_END     = 3'b111;
  localparam logic [AW-1:0] ADDR_INC    = AW'(DW / 8);
  localparam int            WD_W        = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT - 1);

  state_t           state_q;
  logic             cyc_q;
  logic             stb_q;
  logic             we_q;
  logic             len_zero_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    dat_q;
  logic [2:0]       cti_q;
  logic [LEN_W-1:0] cnt_q;
  logic [WD_W-1:0]  wd_q;
  logic [DW-1:0]    rd_data_q;
  logic             rd_valid_q;
  logic             err_q;

  logic [AW-1:0]    addr_d;
  logic [LEN_W-1:0] cnt_d;
  logic [WD_W-1:0]  wd_d;

  // Burst type for the beat about to be presented: classic for a single
  // beat, end-of-burst when no beats remain after this one, else incrementing.
  function automatic logic [2:0] cti_for(input logic lz, input logic [LEN_W-1:0] remaining);
    if (lz) begin
      return CTI_CLASSIC;
    end else if (remaining == '0) begin
      return CTI_END;
    end else begin
      return CTI_INCR;
    end
  endfunction

  // Arithmetic for the next beat; address wraps naturally at 2**AW.
  always_comb begin
    addr_d = addr_q + ADDR_INC;
    cnt_d  = cnt_q - 1'b1;
    wd_d   = wd_q + 1'b1;
  end

  // Main FSM: all Wishbone and stream outputs are driven from these registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      len_zero_q <= 1'b0;
      addr_q     <= '0;
      dat_q      <= '0;
      cti_q      <= CTI_CLASSIC;
      cnt_q      <= '0;
      wd_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            we_q       <= cmd_we;
            len_zero_q <= (cmd_len == '0);
            cnt_q      <= cmd_len;
            addr_q     <= cmd_addr;
            cyc_q      <= 1'b1;
            wd_q       <= '0;
            if (cmd_we) begin
              // CYC goes up now; STB waits for the first write beat.
              state_q <= S_WLOAD;
            end else begin
              stb_q   <= 1'b1;
              cti_q   <= cti_for(cmd_len == '0, cmd_len);
              state_q <= S_STB;
            end
          end
        end

        S_WLOAD: begin
          // No watchdog here: the stall is on our own write stream, not the slave.
          if (wr_valid) begin
            dat_q   <= wr_data;
            stb_q   <= 1'b1;
            cti_q   <= cti_for(len_zero_q, cnt_q);
            wd_q    <= '0;
            state_q <= S_STB;
          end
        end

        S_STB: begin
          if (wb_ack_i) begin
            // An ACK coinciding with watchdog expiry takes priority.
            wd_q <= '0;
            if (!we_q) begin
              rd_data_q  <= wb_dat_i;
              rd_valid_q <= 1'b1;
            end
            if (cnt_q != '0) begin
              cnt_q  <= cnt_d;
              addr_q <= addr_d;
              if (we_q) begin
                // Drop STB while the next write beat is fetched; CYC stays up.
                stb_q   <= 1'b0;
                cti_q   <= CTI_CLASSIC;
                state_q <= S_WLOAD;
              end else begin
                cti_q <= cti_for(1'b0, cnt_d);
              end
            end else begin
              cyc_q   <= 1'b0;
              stb_q   <= 1'b0;
              cti_q   <= CTI_CLASSIC;
              state_q <= S_GAP;
            end
          end else if (wd_q == WD_LAST) begin
            // Hung slave: abandon the rest of the burst and release the bus.
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            cti_q   <= CTI_CLASSIC;
            err_q   <= 1'b1;
            state_q <= S_GAP;
          end else begin
            wd_q <= wd_d;
          end
        end

        S_GAP: begin
          // Guarantees at least one idle bus cycle between transactions.
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign wr_ready    = (state_q == S_WLOAD);
  assign busy        = (state_q != S_IDLE);
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign err_timeout = err_q;

  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = stb_q;
  assign wb_we_o   = we_q;
  assign wb_addr_o = addr_q;
  assign wb_dat_o  = dat_q;
  assign wb_sel_o  = {(DW/8){1'b1}};
  assign wb_cti_o  = cti_q;

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master with a 16-cycle watchdog.
module tb_wb_burst_master;

  localparam int AW = 26;
  localparam int DW = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          busy, err_timeout;
  logic          cyc, stb, we;
  logic [AW-1:0] addr;
  logic [DW-1:0] dat_o;
  logic [3:0]    sel;
  logic [2:0]    cti;
  logic          ack;
  logic [DW-1:0] dat_i;

  int total = 0;
  int bad = 0;
  int rd_pulses = 0;

  wb_burst_master #(.AW(AW), .DW(DW), .LEN_W(LW), .TIMEOUT(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .err_timeout(err_timeout),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we),
    .wb_addr_o(addr), .wb_dat_o(dat_o), .wb_sel_o(sel), .wb_cti_o(cti),
    .wb_ack_i(ack), .wb_dat_i(dat_i)
  );

  always #5 clk = ~clk;

  // Count read pulses and check STB implies CYC every cycle.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) rd_pulses++;
    total++;
    if (stb === 1'b1 && cyc !== 1'b1) begin
      bad++;
      $display("FAIL stb_implies_cyc stb=%b cyc=%b t=%0t", stb, cyc, $time);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 0; cmd_we = 0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 0; wr_data = '0; ack = 0; dat_i = '0;
    repeat (3) tick();
    total++; if ({cyc, stb, we, rd_valid, err_timeout, busy} !== 6'b0) begin bad++; $display("FAIL reset_ctrl got=%b exp=000000", {cyc, stb, we, rd_valid, err_timeout, busy}); end
    total++; if (addr !== '0 || dat_o !== '0 || rd_data !== '0 || cti !== 3'b000) begin bad++; $display("FAIL reset_data addr=%h dat=%h rd=%h cti=%b exp all 0", addr, dat_o, rd_data, cti); end
    total++; if (sel !== 4'hF) begin bad++; $display("FAIL sel got=%h exp=f", sel); end
    rst = 1'b0;
    tick();
    total++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || cyc !== 1'b0) begin bad++; $display("FAIL reset_release rdy=%b busy=%b cyc=%b exp 1/0/0", cmd_ready, busy, cyc); end
  endtask

  task automatic test_single_read();
    cmd_valid = 1; cmd_we = 0; cmd_addr = 26'h100; cmd_len = 0;
    tick();
    cmd_valid = 0;
    total++; if (cyc !== 1 || stb !== 1 || addr !== 26'h100 || cti !== 3'b000 || we !== 0) begin bad++; $display("FAIL sr_first cyc=%b stb=%b addr=%h cti=%b we=%b exp 1/1/100/000/0", cyc, stb, addr, cti, we); end
    total++; if (cmd_ready !== 0 || busy !== 1) begin bad++; $display("FAIL sr_busy rdy=%b busy=%b exp 0/1", cmd_ready, busy); end
    tick();
    total++; if (stb !== 1 || rd_valid !== 0) begin bad++; $display("FAIL sr_wait stb=%b rdv=%b exp 1/0", stb, rd_valid); end
    ack = 1; dat_i = 32'hDEADBEEF;
    tick();
    ack = 0;
    total++; if (cyc !== 0 || stb !== 0 || rd_valid !== 1 || rd_data !== 32'hDEADBEEF) begin bad++; $display("FAIL sr_data cyc=%b stb=%b rdv=%b rd=%h exp 0/0/1/deadbeef", cyc, stb, rd_valid, rd_data); end
    total++; if (busy !== 1 || cmd_ready !== 0) begin bad++; $display("FAIL sr_gap busy=%b rdy=%b exp 1/0", busy, cmd_ready); end
    tick();
    total++; if (busy !== 0 || cmd_ready !== 1 || rd_valid !== 0) begin bad++; $display("FAIL sr_idle busy=%b rdy=%b rdv=%b exp 0/1/0", busy, cmd_ready, rd_valid); end
  endtask

  task automatic test_read_burst();
    logic [2:0] exp_cti;
    cmd_valid = 1; cmd_we = 0; cmd_addr = 26'h0; cmd_len = 3;
    tick();
    cmd_valid = 0;
    for (int i = 0; i < 4; i++) begin
      exp_cti = (i == 3) ? 3'b111 : 3'b010;
      total++; if (stb !== 1 || cyc !== 1 || addr !== 26'(4 * i) || cti !== exp_cti) begin bad++; $display("FAIL rb_beat%0d stb=%b cyc=%b addr=%h cti=%b exp 1/1/%h/%b", i, stb, cyc, addr, cti, 26'(4 * i), exp_cti); end
      ack = 1; dat_i = 32'hA0 + 32'(i);
      tick();
      total++; if (rd_valid !== 1 || rd_data !== 32'hA0 + 32'(i)) begin bad++; $display("FAIL rb_rd%0d rdv=%b rd=%h exp 1/%h", i, rd_valid, rd_data, 32'hA0 + 32'(i)); end
    end
    ack = 0;
    total++; if (cyc !== 0 || stb !== 0) begin bad++; $display("FAIL rb_end cyc=%b stb=%b exp 0/0", cyc, stb); end
    tick();
  endtask

  task automatic test_write_burst();
    logic [DW-1:0] wd [2];
    wd[0] = 32'h11223344; wd[1] = 32'hCAFEF00D;
    cmd_valid = 1; cmd_we = 1; cmd_addr = 26'h200; cmd_len = 1;
    tick();
    cmd_valid = 0;
    for (int b = 0; b < 2; b++) begin
      repeat (3) begin
        total++; if (cyc !== 1 || stb !== 0 || wr_ready !== 1 || cmd_ready !== 0) begin bad++; $display("FAIL wb_wload%0d cyc=%b stb=%b wrdy=%b crdy=%b exp 1/0/1/0", b, cyc, stb, wr_ready, cmd_ready); end
        tick();
      end
      wr_valid = 1; wr_data = wd[b];
      tick();
      wr_valid = 0;
      total++; if (stb !== 1 || we !== 1 || dat_o !== wd[b] || addr !== 26'h200 + 26'(4 * b) || wr_ready !== 0) begin bad++; $display("FAIL wb_beat%0d stb=%b we=%b dat=%h addr=%h wrdy=%b exp 1/1/%h/%h/0", b, stb, we, dat_o, addr, wr_ready, wd[b], 26'h200 + 26'(4 * b)); end
      total++; if (cti !== ((b == 1) ? 3'b111 : 3'b010)) begin bad++; $display("FAIL wb_cti%0d got=%b exp=%b", b, cti, (b == 1) ? 3'b111 : 3'b010); end
      ack = 1;
      tick();
      ack = 0;
      total++; if (cyc !== ((b == 0) ? 1'b1 : 1'b0) || stb !== 0 || rd_valid !== 0) begin bad++; $display("FAIL wb_ack%0d cyc=%b stb=%b rdv=%b exp %b/0/0", b, cyc, stb, rd_valid, (b == 0) ? 1'b1 : 1'b0); end
    end
    tick();
    total++; if (busy !== 0) begin bad++; $display("FAIL wb_idle busy=%b exp 0", busy); end
  endtask

  task automatic test_timeout();
    int stb_cycles = 0;
    int errs = 0;
    int p0;
    p0 = rd_pulses;
    cmd_valid = 1; cmd_we = 0; cmd_addr = 26'h300; cmd_len = 2;
    tick();
    cmd_valid = 0;
    for (int c = 0; c < 40; c++) begin
      if (stb === 1) stb_cycles++;
      if (err_timeout === 1) begin
        errs++;
        total++; if (cyc !== 0 || busy !== 1) begin bad++; $display("FAIL to_abort cyc=%b busy=%b exp 0/1", cyc, busy); end
      end
      tick();
    end
    total++; if (stb_cycles != 16) begin bad++; $display("FAIL to_stb_len got=%0d exp=16", stb_cycles); end
    total++; if (errs != 1) begin bad++; $display("FAIL to_err_pulses got=%0d exp=1", errs); end
    total++; if (rd_pulses != p0 || cyc !== 0) begin bad++; $display("FAIL to_quiet rd=%0d cyc=%b exp %0d/0", rd_pulses, cyc, p0); end
    // Next command must be accepted after the abort.
    total++; if (cmd_ready !== 1) begin bad++; $display("FAIL to_rdy got=%b exp=1", cmd_ready); end
    cmd_valid = 1; cmd_addr = 26'h400; cmd_len = 0;
    tick();
    cmd_valid = 0;
    total++; if (stb !== 1 || addr !== 26'h400) begin bad++; $display("FAIL to_next stb=%b addr=%h exp 1/400", stb, addr); end
    ack = 1; dat_i = 32'h5A5A0001;
    tick();
    ack = 0;
    total++; if (rd_valid !== 1 || rd_data !== 32'h5A5A0001) begin bad++; $display("FAIL to_next_rd rdv=%b rd=%h exp 1/5a5a0001", rd_valid, rd_data); end
    tick();
  endtask

  task automatic test_ack_at_expiry();
    cmd_valid = 1; cmd_we = 0; cmd_addr = 26'h3FFFFFC; cmd_len = 0;
    tick();
    cmd_valid = 0;
    repeat (15) tick();
    total++; if (stb !== 1) begin bad++; $display("FAIL ex_stb15 got=%b exp=1", stb); end
    ack = 1; dat_i = 32'h0BADF00D;
    tick();
    ack = 0;
    total++; if (err_timeout !== 0 || rd_valid !== 1 || rd_data !== 32'h0BADF00D || cyc !== 0) begin bad++; $display("FAIL ex_ackwins err=%b rdv=%b rd=%h cyc=%b exp 0/1/0badf00d/0", err_timeout, rd_valid, rd_data, cyc); end
    tick();
    total++; if (err_timeout !== 0 || busy !== 0) begin bad++; $display("FAIL ex_after err=%b busy=%b exp 0/0", err_timeout, busy); end
  endtask

  task automatic test_spurious_ack();
    int p0;
    p0 = rd_pulses;
    ack = 1; dat_i = 32'hFFFF0000;
    repeat (3) tick();
    total++; if (rd_valid !== 0 || busy !== 0 || cyc !== 0) begin bad++; $display("FAIL sp_idle rdv=%b busy=%b cyc=%b exp 0/0/0", rd_valid, busy, cyc); end
    cmd_valid = 1; cmd_we = 1; cmd_addr = 26'h500; cmd_len = 0;
    tick();
    cmd_valid = 0;
    repeat (2) tick();
    total++; if (stb !== 0 || addr !== 26'h500 || wr_ready !== 1) begin bad++; $display("FAIL sp_wload stb=%b addr=%h wrdy=%b exp 0/500/1", stb, addr, wr_ready); end
    ack = 0; wr_valid = 1; wr_data = 32'h77778888;
    tick();
    wr_valid = 0;
    total++; if (stb !== 1 || addr !== 26'h500 || dat_o !== 32'h77778888) begin bad++; $display("FAIL sp_stb stb=%b addr=%h dat=%h exp 1/500/77778888", stb, addr, dat_o); end
    ack = 1;
    tick();
    total++; if (cyc !== 0 || busy !== 1) begin bad++; $display("FAIL sp_gap cyc=%b busy=%b exp 0/1", cyc, busy); end
    tick();
    total++; if (busy !== 0 || cyc !== 0 || addr !== 26'h500) begin bad++; $display("FAIL sp_after busy=%b cyc=%b addr=%h exp 0/0/500", busy, cyc, addr); end
    ack = 0;
    tick();
    total++; if (rd_pulses != p0) begin bad++; $display("FAIL sp_no_rd got=%0d exp=%0d", rd_pulses, p0); end
  endtask

  task automatic test_reset_mid_burst();
    int p0;
    cmd_valid = 1; cmd_we = 0; cmd_addr = 26'h40; cmd_len = 7;
    tick();
    cmd_valid = 0;
    ack = 1; dat_i = 32'h12340000;
    repeat (2) tick();
    total++; if (stb !== 1 || addr !== 26'h48) begin bad++; $display("FAIL rm_pre stb=%b addr=%h exp 1/48", stb, addr); end
    rst = 1;
    tick();
    total++; if (cyc !== 0 || stb !== 0 || rd_valid !== 0 || busy !== 0) begin bad++; $display("FAIL rm_ctrl cyc=%b stb=%b rdv=%b busy=%b exp 0/0/0/0", cyc, stb, rd_valid, busy); end
    total++; if (addr !== '0 || rd_data !== '0 || cti !== 3'b000) begin bad++; $display("FAIL rm_data addr=%h rd=%h cti=%b exp 0/0/000", addr, rd_data, cti); end
    p0 = rd_pulses;
    rst = 0; ack = 0;
    repeat (3) tick();
    total++; if (rd_pulses != p0 || cyc !== 0 || cmd_ready !== 1) begin bad++; $display("FAIL rm_after rd=%0d cyc=%b rdy=%b exp %0d/0/1", rd_pulses, cyc, cmd_ready, p0); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_read_burst();
    test_write_burst();
    test_timeout();
    test_ack_at_expiry();
    test_spurious_ack();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_burst_master.md
Name: wb_burst_master

Overview:
- Synthesizable Wishbone B3 master that sits directly upstream of the SDRAM controller's Wishbone slave port (wb_*_i of the controller) and generates the cycles the whitebox protocol checks observe.
- Converts a simple command/write-data stream into single or incrementing-burst Wishbone cycles and returns read data on a response stream.
- Includes a per-beat ack watchdog so a hung slave cannot lock the bus.

Parameters:
- AW, 26, Wishbone address width (byte address).
- DW, 32, Wishbone data width. Must be a power of two ≥ 8.
- LEN_W, 8, width of the burst length field (max beats = 2**LEN_W).
- TIMEOUT, 256, cycles STB may stay high without ACK before abort (≥ 2).

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge.
- wb_rst_i  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when valid & ready.
- cmd_we  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  AW  start byte address, DW/8 aligned.
- cmd_len  in  LEN_W  beats minus one.
- wr_valid  in  1  write beat data present.
- wr_ready  out  1  write beat consumed when valid & ready.
- wr_data  in  DW  write beat data.
- rd_valid  out  1  one-cycle pulse per read beat; no backpressure.
- rd_data  out  DW  read beat data.
- busy  out  1  high when state ≠ IDLE.
- err_timeout  out  1  one-cycle pulse on watchdog abort.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone controls.
- wb_addr_o  out  AW  Wishbone address.
- wb_dat_o  out  DW  Wishbone write data.
- wb_sel_o  out  DW/8  byte selects; all ones.
- wb_cti_o  out  3  cycle type identifier.
- wb_ack_i  in  1  slave acknowledge.
- wb_dat_i  in  DW  slave read data.

Behaviour:
- Reset:
  - State is IDLE.
  - wb_cyc_o, wb_stb_o, wb_we_o, rd_valid, err_timeout and busy are 0.
  - wb_addr_o, wb_dat_o and rd_data are 0; wb_cti_o is 000.
  - Reset asserted mid-burst forces all of the above on the next edge, with no completion beat.
- All Wishbone outputs are registered.
- Invariants:
  - wb_stb_o implies wb_cyc_o.
  - wb_cyc_o never drops while wb_stb_o is high except on the last ACK, on abort, or on reset.
- States IDLE, WLOAD, STB, GAP:
  - IDLE:
    - cmd_ready = 1.
    - On handshake, latch we/addr/len and set beat counter = len.
    - Next state: WLOAD if write, else STB.
    - wb_cyc_o rises together with the first STB (reads) or the first WLOAD cycle (writes).
  - WLOAD:
    - wb_cyc_o = 1, wb_stb_o = 0, wr_ready = 1.
    - On wr_valid, latch wr_data into wb_dat_o and go to STB.
    - Waits indefinitely; the watchdog is not running in WLOAD.
  - STB:
    - wb_stb_o = 1. wb_we_o = latched we.
    - wb_cti_o = 000 if len == 0; otherwise 010 on non-final beats and 111 on the final beat.
    - On wb_ack_i with counter ≠ 0:
      - decrement counter;
      - wb_addr_o += DW/8, wrapping modulo 2**AW;
      - read: remain in STB (back-to-back beats);
      - write: go to WLOAD (STB low for ≥ 1 cycle).
    - On wb_ack_i with counter == 0: next cycle cyc = stb = 0, state GAP.
  - GAP: one idle cycle with cyc = 0, then IDLE. This guarantees at least one cycle between transactions.
- Read data:
  - On each ACK while in STB with we = 0, rd_data <= wb_dat_i.
  - rd_valid pulses high on the following cycle. Latency from ACK is 1.
- wb_ack_i is ignored outside STB; no state change and no rd_valid.
- Watchdog:
  - Counter clears on entry to STB and on every ACK, and increments each STB cycle without ACK.
  - At TIMEOUT-1 without ACK: next cycle cyc = stb = 0, err_timeout = 1 for one cycle, state GAP.
  - Remaining beats are dropped.
  - An ACK arriving in the same cycle as the expiry wins; no abort occurs.
- cmd_ready = 0 and wr_ready = 0 in all states other than IDLE and WLOAD respectively.

Test Plan:
- Reset with all stimulus quiet, then release → cyc = stb = 0, cmd_ready = 1, busy = 0. Assert wb_rst_i mid-read-burst → cyc = stb = 0 on the next edge, no further rd_valid.
- Single read: addr 0x100, len 0, slave ACKs on 2nd STB cycle with 0xDEADBEEF → cti = 000, one rd_valid with 0xDEADBEEF one cycle after ACK, then one GAP cycle.
- Read burst: addr 0x0, len 3, slave ACKs every cycle → addresses 0x0/0x4/0x8/0xC, cti 010, 010, 010, 111, four back-to-back rd_valid pulses, stb continuous.
- Write burst: len 1, wr_valid delayed 3 cycles before each beat → cyc stays high, stb low in WLOAD, wb_dat_o matches each wr_data, two ACKs end the cycle.
- Slave never ACKs, TIMEOUT = 16 → stb high exactly 16 cycles, then cyc = stb = 0 and a single err_timeout pulse; the next command is accepted after GAP.
- Spurious wb_ack_i in IDLE/GAP/WLOAD → no rd_valid, no address advance; the whitebox assertions (cyc/stb after reset, stb⇒cyc) pass throughout.
